// File: rtl/multicycle_control_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multicycle_control_if : control/status bundle between LEGv8 datapath and FSM
// Revision 1.0
// ----------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [10:0]      opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             iord;
  logic             reg_write;
  logic             mem_to_reg;
  logic             reg2_loc;
  logic [1:0]       alu_src_b;
  logic [3:0]       alu_op;
  logic             flag_write;
  logic             busy;
  logic             illegal;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output run, opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
           mem_to_reg, reg2_loc, alu_src_b, alu_op, flag_write, busy, illegal,
           cycle_cnt, instr_cnt
  );

  modport slave (
    input  run, opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
           mem_to_reg, reg2_loc, alu_src_b, alu_op, flag_write, busy, illegal,
           cycle_cnt, instr_cnt
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multicycle_control : LEGv8 multicycle control FSM with cycle/retire counters
// Revision 1.0
// ----------------------------------------------------------------------------
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_TRAP
  } state_t;

  typedef enum logic [2:0] {C_R, C_LD, C_ST, C_I, C_CBZ, C_B, C_ILL} cls_t;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0111;

  state_t           state_q, state_d;
  cls_t             cls;
  logic [3:0]       op_alu;
  logic             op_flag;
  logic             retire;
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

  // Priority-ordered opcode classification; first match wins.
  always_comb begin
    cls     = C_ILL;
    op_alu  = ALU_ADD;
    op_flag = 1'b0;
    if      (bus.opcode == 11'b10001011000) cls = C_R;
    else if (bus.opcode == 11'b11001011000) begin cls = C_R; op_alu = ALU_SUB; end
    else if (bus.opcode == 11'b10001010000) begin cls = C_R; op_alu = ALU_AND; end
    else if (bus.opcode == 11'b10101010000) begin cls = C_R; op_alu = ALU_ORR; end
    else if (bus.opcode == 11'b10101011000) begin cls = C_R; op_flag = 1'b1; end
    else if (bus.opcode == 11'b11101011000) begin cls = C_R; op_alu = ALU_SUB; op_flag = 1'b1; end
    else if (bus.opcode == 11'b11111000010) cls = C_LD;
    else if (bus.opcode == 11'b11111000000) cls = C_ST;
    else if (bus.opcode[10:1] == 10'b1001000100) cls = C_I;
    else if (bus.opcode[10:1] == 10'b1011000100) begin cls = C_I; op_flag = 1'b1; end
    else if (bus.opcode[10:1] == 10'b1101000100) begin cls = C_I; op_alu = ALU_SUB; end
    else if (bus.opcode[10:1] == 10'b1111000100) begin cls = C_I; op_alu = ALU_SUB; op_flag = 1'b1; end
    else if (bus.opcode[10:3] == 8'b10110100) cls = C_CBZ;
    else if (bus.opcode[10:5] == 6'b000101) cls = C_B;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != S_TRAP && (bus.run || state_q != S_FETCH))
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (retire)
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  // Strobes are forced low while reset is held so nothing fires on the reset edge.
  always_comb begin
    state_d        = state_q;
    retire         = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'b00;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg2_loc   = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 4'b0000;
    bus.flag_write = 1'b0;
    bus.busy       = 1'b0;
    bus.illegal    = 1'b0;
    if (!reset) begin
      bus.busy = (state_q != S_FETCH);
      case (state_q)
        S_FETCH: begin
          if (bus.run) begin
            bus.mem_read = 1'b1;
            if (bus.mem_ready) begin
              bus.ir_write = 1'b1;
              bus.pc_write = 1'b1;
              state_d      = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          case (cls)
            C_R:          state_d = S_EXEC_R;
            C_I:          state_d = S_EXEC_I;
            C_LD, C_ST:   state_d = S_ADDR;
            C_CBZ, C_B:   state_d = S_BRANCH;
            default:      state_d = S_TRAP;
          endcase
        end
        S_EXEC_R, S_EXEC_I: begin
          bus.alu_src_b  = (state_q == S_EXEC_I) ? 2'b01 : 2'b00;
          bus.alu_op     = op_alu;
          bus.flag_write = op_flag;
          state_d        = S_WB_ALU;
        end
        S_ADDR: begin
          bus.alu_src_b = 2'b10;
          bus.alu_op    = ALU_ADD;
          bus.reg2_loc  = 1'b1;
          state_d       = (cls == C_LD) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          bus.mem_read = 1'b1;
          bus.iord     = 1'b1;
          if (bus.mem_ready) state_d = S_WB_MEM;
        end
        S_MEM_WR: begin
          bus.mem_write = 1'b1;
          bus.iord      = 1'b1;
          bus.reg2_loc  = 1'b1;
          if (bus.mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_WB_ALU, S_WB_MEM: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = (state_q == S_WB_MEM);
          retire         = 1'b1;
          state_d        = S_FETCH;
        end
        S_BRANCH: begin
          if (cls == C_CBZ) begin
            bus.reg2_loc = 1'b1;
            bus.alu_op   = ALU_PASS;
            bus.pc_src   = 2'b01;
            bus.pc_write = bus.zero;
          end else begin
            bus.pc_src   = 2'b10;
            bus.pc_write = 1'b1;
          end
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        S_TRAP:  bus.illegal = 1'b1;
        default: state_d = S_TRAP;
      endcase
    end
  end

  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.instr_cnt = instr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_multicycle_control : randomized instruction streams vs. a per-cycle model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) bus ();
  multicycle_control #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  // Output vector: {pc_write, pc_src, ir_write, mem_read, mem_write, iord,
  // reg_write, mem_to_reg, reg2_loc, alu_src_b, alu_op, flag_write, busy, illegal}
  logic [18:0] vec;
  assign vec = {bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write,
                bus.iord, bus.reg_write, bus.mem_to_reg, bus.reg2_loc, bus.alu_src_b,
                bus.alu_op, bus.flag_write, bus.busy, bus.illegal};

  localparam logic [18:0] PCW = 19'h1 << 18, PCS1 = 19'h1 << 16, PCS2 = 19'h1 << 17;
  localparam logic [18:0] IRW = 19'h1 << 15, MRD = 19'h1 << 14, MWR = 19'h1 << 13;
  localparam logic [18:0] IORD = 19'h1 << 12, RW = 19'h1 << 11, M2R = 19'h1 << 10;
  localparam logic [18:0] R2L = 19'h1 << 9, SRCB1 = 19'h1 << 7, SRCB2 = 19'h1 << 8;
  localparam logic [18:0] FW = 19'h1 << 2, BUSY = 19'h1 << 1, ILL = 19'h1;

  // rdy: 0/1 forced mem_ready, 2 = don't care (randomized)
  typedef struct packed {
    logic [18:0] out;
    logic [1:0]  rdy;
    logic        cnt;
    logic        ret;
  } step_t;

  step_t       q[$];
  logic [31:0] m_cyc, m_ins;
  int          n_checks = 0, n_pass = 0;

  function automatic logic [18:0] alu(input logic [3:0] a);
    return {11'd0, a, 3'd0};
  endfunction

  function automatic void push(input logic [18:0] o, input logic [1:0] r, input logic c);
    q.push_back(step_t'{out: o, rdy: r, cnt: c, ret: 1'b0});
  endfunction

  // Classes: 0 R, 1 LD, 2 ST, 3 I, 4 CBZ, 5 B, 6 illegal
  function automatic int m_class(input logic [10:0] op, output logic [3:0] aop, output logic fl);
    aop = 4'b0010; fl = 1'b0;
    case (op)
      11'b10001011000: return 0;
      11'b11001011000: begin aop = 4'b0110; return 0; end
      11'b10001010000: begin aop = 4'b0000; return 0; end
      11'b10101010000: begin aop = 4'b0001; return 0; end
      11'b10101011000: begin fl = 1'b1; return 0; end
      11'b11101011000: begin aop = 4'b0110; fl = 1'b1; return 0; end
      11'b11111000010: return 1;
      11'b11111000000: return 2;
      default: ;
    endcase
    if (op[10:1] == 10'b1001000100) return 3;
    if (op[10:1] == 10'b1011000100) begin fl = 1'b1; return 3; end
    if (op[10:1] == 10'b1101000100) begin aop = 4'b0110; return 3; end
    if (op[10:1] == 10'b1111000100) begin aop = 4'b0110; fl = 1'b1; return 3; end
    if (op[10:3] == 8'b10110100) return 4;
    if (op[10:5] == 6'b000101) return 5;
    return 6;
  endfunction

  // Expected per-cycle outputs for one instruction, mem_ready waits fw (fetch) and mw (memory)
  function automatic void build(input logic [10:0] op, input logic z, input int fw, input int mw,
                                input int traps);
    logic [3:0] aop;
    logic       fl;
    int         c;
    q.delete();
    c = m_class(op, aop, fl);
    for (int i = 0; i < fw; i++) push(MRD, 2'd0, 1'b1);
    push(MRD | IRW | PCW, 2'd1, 1'b1);
    push(BUSY, 2'd2, 1'b1);
    case (c)
      0, 3: begin
        push(BUSY | (c == 3 ? SRCB1 : 19'd0) | alu(aop) | (fl ? FW : 19'd0), 2'd2, 1'b1);
        push(BUSY | RW, 2'd2, 1'b1);
      end
      1, 2: begin
        push(BUSY | SRCB2 | alu(4'b0010) | R2L, 2'd2, 1'b1);
        for (int i = 0; i <= mw; i++)
          push(BUSY | IORD | (c == 1 ? MRD : (MWR | R2L)), (i == mw) ? 2'd1 : 2'd0, 1'b1);
        if (c == 1) push(BUSY | RW | M2R, 2'd2, 1'b1);
      end
      4: push(BUSY | R2L | alu(4'b0111) | PCS1 | (z ? PCW : 19'd0), 2'd2, 1'b1);
      5: push(BUSY | PCS2 | PCW, 2'd2, 1'b1);
      default: for (int i = 0; i < traps; i++) push(BUSY | ILL, 2'd2, 1'b0);
    endcase
    if (c != 6) q[q.size() - 1].ret = 1'b1;
  endfunction

  task automatic drive_step(input step_t s, input logic z);
    @(negedge clk);
    bus.run       = 1'b1;
    bus.zero      = z;
    bus.mem_ready = (s.rdy == 2'd2) ? 1'($urandom_range(0, 1)) : s.rdy[0];
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.run = 1'b1; bus.mem_ready = 1'b1; bus.zero = 1'b1;
    bus.opcode = 11'b10101011000;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (vec !== 19'd0) $display("FAIL reset_outputs: got %b want 0", vec);
    else n_pass++;
    n_checks++;
    if (bus.cycle_cnt !== 32'd0 || bus.instr_cnt !== 32'd0)
      $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.cycle_cnt, bus.instr_cnt);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0; bus.run = 1'b0;
    m_cyc = 0; m_ins = 0;
  endtask

  task automatic test_directed();
    logic [10:0] ops[10] = '{11'b10101011000, 11'b11111000010, 11'b10110100101, 11'b10110100011,
                             11'b00010110110, 11'b11110001000, 11'b11111000000, 11'b10001011000,
                             11'b10001010000, 11'b10101010000};
    logic        zs[10]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int          mws[10] = '{0, 2, 0, 0, 0, 0, 1, 0, 0, 0};
    int          fws[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 2};
    for (int k = 0; k < 10; k++) begin
      bus.opcode = ops[k];
      build(ops[k], zs[k], fws[k], mws[k], 0);
      for (int i = 0; i < q.size(); i++) begin
        drive_step(q[i], zs[k]);
        n_checks++;
        if (vec !== q[i].out)
          $display("FAIL dir_out op=%b step=%0d: got %b want %b", ops[k], i, vec, q[i].out);
        else n_pass++;
        n_checks++;
        if (bus.cycle_cnt !== m_cyc || bus.instr_cnt !== m_ins)
          $display("FAIL dir_cnt op=%b step=%0d: got %0d/%0d want %0d/%0d", ops[k], i,
                   bus.cycle_cnt, bus.instr_cnt, m_cyc, m_ins);
        else n_pass++;
        m_cyc += 32'(q[i].cnt);
        m_ins += 32'(q[i].ret);
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] legal[8] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                              11'b10101011000, 11'b11101011000, 11'b11111000010, 11'b11111000000};
    logic [10:0] op;
    logic        z;
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    op = legal[$urandom_range(0, 7)];
        2:       op = {$urandom_range(0, 3) == 0 ? 4'b1001 : 4'b1111, 6'b000100, 1'($urandom)};
        default: op = ($urandom_range(0, 1) == 1) ? {8'b10110100, 3'($urandom)}
                                                  : {6'b000101, 5'($urandom)};
      endcase
      z = 1'($urandom);
      bus.opcode = op;
      build(op, z, $urandom_range(0, 2), $urandom_range(0, 3), 0);
      for (int i = 0; i < q.size(); i++) begin
        drive_step(q[i], z);
        n_checks++;
        if (vec !== q[i].out)
          $display("FAIL rnd_out op=%b step=%0d: got %b want %b", op, i, vec, q[i].out);
        else n_pass++;
        n_checks++;
        if (bus.cycle_cnt !== m_cyc || bus.instr_cnt !== m_ins)
          $display("FAIL rnd_cnt op=%b step=%0d: got %0d/%0d want %0d/%0d", op, i,
                   bus.cycle_cnt, bus.instr_cnt, m_cyc, m_ins);
        else n_pass++;
        m_cyc += 32'(q[i].cnt);
        m_ins += 32'(q[i].ret);
      end
    end
  endtask

  task automatic test_trap();
    bus.opcode = 11'b00000000000;
    build(bus.opcode, 1'b0, 1, 0, 6);
    for (int i = 0; i < q.size(); i++) begin
      drive_step(q[i], 1'($urandom));
      n_checks++;
      if (vec !== q[i].out) $display("FAIL trap_out step=%0d: got %b want %b", i, vec, q[i].out);
      else n_pass++;
      n_checks++;
      if (bus.cycle_cnt !== m_cyc || bus.instr_cnt !== m_ins)
        $display("FAIL trap_cnt step=%0d: got %0d/%0d want %0d/%0d", i,
                 bus.cycle_cnt, bus.instr_cnt, m_cyc, m_ins);
      else n_pass++;
      m_cyc += 32'(q[i].cnt);
      m_ins += 32'(q[i].ret);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.illegal !== 1'b0 || vec !== 19'd0)
      $display("FAIL trap_reset: got illegal=%b vec=%b want 0", bus.illegal, vec);
    else n_pass++;
    m_cyc = 0; m_ins = 0;
    @(negedge clk);
    reset = 1'b0; bus.run = 1'b0;
  endtask

  task automatic test_reset_in_store();
    bus.opcode = 11'b11111000000;
    build(bus.opcode, 1'b0, 0, 3, 0);
    for (int i = 0; i < 4; i++) begin
      drive_step(q[i], 1'b0);
      n_checks++;
      if (vec !== q[i].out) $display("FAIL st_out step=%0d: got %b want %b", i, vec, q[i].out);
      else n_pass++;
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (vec !== 19'd0 || bus.cycle_cnt !== 32'd0 || bus.instr_cnt !== 32'd0)
      $display("FAIL st_reset: got vec=%b cnt=%0d/%0d want 0", vec, bus.cycle_cnt, bus.instr_cnt);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0; bus.run = 1'b0; bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (vec !== 19'd0 || bus.cycle_cnt !== 32'd0)
        $display("FAIL pause cyc=%0d: got vec=%b cycle_cnt=%0d want 0/0", i, vec, bus.cycle_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_trap();
    test_reset_in_store();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
